// File: rtl/axi_boot_rom.sv
// axi_boot_rom -- AXI4 read-only slave for the boot ROM window.
//
// Serves FIXED/INCR/WRAP read bursts of up to 256 beats from an inferred
// synchronous block RAM. There is no write channel. Each issued beat passes
// through one memory read stage and then a 2-entry output skid buffer. Reads
// are only issued when the buffer is guaranteed to have room, so rready
// backpressure never drops a beat.
//
// Optional feature macro: ROM_BOUNDS_CHECK_EN. When it is defined, any beat
// whose word index is >= DEPTH_WORDS returns rdata=0 with rresp=SLVERR.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axi_ar*       read address channel (araddr bits [MEM_ADDR_BITS+1:2] used)
//   s_axi_r*        read data channel (rdata, rresp, rlast, rvalid/rready)
module axi_boot_rom #(
   parameter int unsigned MEM_ADDR_BITS = 14,
   parameter int unsigned DEPTH_WORDS   = 16384,
   parameter string       INIT_FILE     = "boot.hex"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [31:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        s_axi_rlast,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp
);

   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic {StIdle, StBurst} state_e;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic [31:0] mem [2**MEM_ADDR_BITS];

   state_e                   state_q, state_d;
   logic                     arready_q, arready_d;
   logic [MEM_ADDR_BITS-1:0] idx_q, idx_d, idx_next, wrap_mask;
   logic [7:0]               beats_q, beats_d;
   logic [1:0]               burst_q, burst_d;
   logic [3:0]               len_q, len_d;
   logic                     err_q, err_d;
   logic                     done_q, done_d;

   logic                     s1_valid_q, s1_last_q, s1_err_q;
   logic [31:0]              rd_data_q;

   beat_t                    buf0_q, buf0_d, buf1_q, buf1_d, push_beat;
   logic [1:0]               count_q, count_d;

   logic                     ar_hs, ar_err, pop, issue, oob;
   logic [2:0]               occ;

   logic                     unused_addr;
   assign unused_addr = ^{s_axi_araddr[31:MEM_ADDR_BITS+2], s_axi_araddr[1:0]};

   assign ar_hs = s_axi_arvalid & arready_q;
   assign ar_err = (s_axi_arsize != 3'b010) || (s_axi_arburst == 2'b11) ||
                   ((s_axi_arburst == BurstWrap) &&
                    !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

   assign pop = (count_q != 2'd0) & s_axi_rready;

   // Entries that will occupy the skid buffer after this edge must not exceed
   // two: buffered beats, minus the one leaving, plus the beat in the read stage.
   assign occ   = 3'(count_q) + 3'(s1_valid_q);
   assign issue = (state_q == StBurst) && !done_q && (occ <= 3'd1 + 3'(pop));

`ifdef ROM_BOUNDS_CHECK_EN
   assign oob = 32'(idx_q) >= DEPTH_WORDS;
`else
   assign oob = 1'b0;
`endif

   // Legal WRAP lengths are 2^n-1, so arlen itself is the mask of wrapping bits.
   assign wrap_mask = MEM_ADDR_BITS'(len_q);

   always_comb begin
      idx_next = idx_q;
      case (burst_q)
         BurstIncr: idx_next = idx_q + MEM_ADDR_BITS'(1);
         BurstWrap: idx_next = (idx_q & ~wrap_mask) |
                               ((idx_q + MEM_ADDR_BITS'(1)) & wrap_mask);
         default:   idx_next = idx_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      arready_d = arready_q;
      idx_d     = idx_q;
      beats_d   = beats_q;
      burst_d   = burst_q;
      len_d     = len_q;
      err_d     = err_q;
      done_d    = done_q;
      unique case (state_q)
         StIdle: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               state_d   = StBurst;
               arready_d = 1'b0;
               idx_d     = s_axi_araddr[MEM_ADDR_BITS+1:2];
               beats_d   = s_axi_arlen;
               burst_d   = s_axi_arburst;
               len_d     = s_axi_arlen[3:0];
               err_d     = ar_err;
               done_d    = 1'b0;
            end
         end
         StBurst: begin
            if (issue) begin
               idx_d = idx_next;
               if (beats_q == 8'd0) done_d = 1'b1;
               else beats_d = beats_q - 8'd1;
            end
            if (pop && buf0_q.last) begin
               state_d   = StIdle;
               arready_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign push_beat = '{data: s1_err_q ? 32'd0 : rd_data_q,
                        resp: s1_err_q ? RespSlverr : RespOkay,
                        last: s1_last_q};

   // buf0 is the presented beat; buf1 only fills while the output is stalled.
   always_comb begin
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      count_d = count_q;
      unique case ({s1_valid_q, pop})
         2'b10: begin
            if (count_q == 2'd0) buf0_d = push_beat;
            else buf1_d = push_beat;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               buf0_d = push_beat;
            end else begin
               buf0_d = buf1_q;
               buf1_d = push_beat;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         arready_q  <= 1'b0;
         idx_q      <= '0;
         beats_q    <= '0;
         burst_q    <= '0;
         len_q      <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_err_q   <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         arready_q  <= arready_d;
         idx_q      <= idx_d;
         beats_q    <= beats_d;
         burst_q    <= burst_d;
         len_q      <= len_d;
         err_q      <= err_d;
         done_q     <= done_d;
         s1_valid_q <= issue;
         if (issue) begin
            s1_last_q <= (beats_q == 8'd0);
            s1_err_q  <= err_q | oob;
         end
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         count_q    <= count_d;
      end
   end

   // Kept free of reset so the array read maps onto block RAM.
   always_ff @(posedge clk) begin
      if (issue) rd_data_q <= mem[idx_q];
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = (count_q != 2'd0);
   assign s_axi_rdata   = buf0_q.data;
   assign s_axi_rresp   = buf0_q.resp;
   assign s_axi_rlast   = buf0_q.last;

endmodule

// File: tb/tb_axi_boot_rom.sv
// tb_axi_boot_rom -- self-checking bench for axi_boot_rom.
// The ROM image is written straight into the DUT array (INIT_FILE is empty).
// MEM_ADDR_BITS=15 with DEPTH_WORDS=16384 lets one build exercise the bounds
// check feature across the DEPTH_WORDS boundary.
module tb_axi_boot_rom;

   localparam int unsigned Aw    = 15;
   localparam int unsigned Depth = 16384;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = 3'd2;
   logic [1:0]  arburst = 2'b01;
   logic        rvalid;
   logic        rready;
   logic        rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      bit          bp;
      bit          exp_err;
      int          exp_first;
   } vec_t;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    n_pops = 0;
   bit    bp_mode = 1'b0;
   int    bp_idx = 0;
   logic [3:0] bp_pat = 4'b1001;

   axi_boot_rom #(
      .MEM_ADDR_BITS(Aw),
      .DEPTH_WORDS  (Depth),
      .INIT_FILE    ("")
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_araddr (araddr),
      .s_axi_arlen  (arlen),
      .s_axi_arsize (arsize),
      .s_axi_arburst(arburst),
      .s_axi_rvalid (rvalid),
      .s_axi_rready (rready),
      .s_axi_rlast  (rlast),
      .s_axi_rdata  (rdata),
      .s_axi_rresp  (rresp)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word_val(input int i);
      if (i == 0) return 32'hDEADBEEF;
      if (i < 64) return 32'(i);
      return 32'hC0DE0000 | 32'(i & 16'hFFFF);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l);
      beat_t b;
      b.data = d;
      b.resp = r;
      b.last = l;
      sb.push_back(b);
   endtask

   // Reference AXI address sequence for a burst starting at word 'first'.
   task automatic push_burst(input int first, input logic [7:0] len, input logic [1:0] burst,
                             input bit err);
      int idx;
      int mask;
      idx  = first;
      mask = int'(len[3:0]);
      for (int b = 0; b <= int'(len); b++) begin
         push(err ? 32'd0 : word_val(idx), err ? 2'b10 : 2'b00, b == int'(len));
         if (burst == 2'b01) idx = (idx + 1) % (1 << Aw);
         else if (burst == 2'b10) idx = (idx & ~mask) | ((idx + 1) & mask);
      end
   endtask

   // Returns just after the handshake edge.
   task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
      int t;
      t = 0;
      @(negedge clk);
      while (!arready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!arready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ar_timeout: arready got 0 expected 1 within 200 cycles");
         return;
      end
      araddr  = a;
      arlen   = l;
      arsize  = s;
      arburst = b;
      arvalid = 1'b1;
      @(posedge clk);
      #1 arvalid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_outstanding", 32'(sb.size()), 32'd0);
   endtask

   // rready driver: always high, or the 1,0,0,1 pattern.
   initial begin
      rready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            rready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
         end else begin
            rready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   initial begin
      beat_t e;
      beat_t held;
      bit    stall_prev;
      stall_prev = 1'b0;
      held = '{32'd0, 2'd0, 1'b0};
      forever begin
         @(negedge clk);
         if (stall_prev && !rst) begin
            n_checks++;
            if (!(rvalid && rdata == held.data && rresp == held.resp && rlast == held.last)) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%0b d=%h r=%0d l=%0b expected v=1 d=%h r=%0d l=%0b",
                        rvalid, rdata, rresp, rlast, held.data, held.resp, held.last);
            end
         end
         stall_prev = rvalid && !rready && !rst;
         held.data  = rdata;
         held.resp  = rresp;
         held.last  = rlast;
         if (rvalid && rready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL extra_beat: got d=%h r=%0d l=%0b expected no beat", rdata, rresp, rlast);
            end else begin
               e = sb.pop_front();
               n_pops++;
               if (rdata !== e.data || rresp !== e.resp || rlast !== e.last) begin
                  n_fail++;
                  $display("FAIL beat: got d=%h r=%0d l=%0b expected d=%h r=%0d l=%0b",
                           rdata, rresp, rlast, e.data, e.resp, e.last);
               end
            end
         end
      end
   end

   initial begin
      vec_t vecs[12];
      int   p0;
      int   t;
      int   wi;

      vecs[0]  = '{32'hFFFE0000, 8'd0,  3'd2, 2'b01, 1'b0, 1'b0, 0};
      vecs[1]  = '{32'hFFFE0010, 8'd7,  3'd2, 2'b01, 1'b0, 1'b0, 4};
      vecs[2]  = '{32'hFFFE0010, 8'd7,  3'd2, 2'b01, 1'b1, 1'b0, 4};
      vecs[3]  = '{32'hFFFE0018, 8'd3,  3'd2, 2'b10, 1'b0, 1'b0, 6};
      vecs[4]  = '{32'hFFFE0018, 8'd2,  3'd2, 2'b10, 1'b0, 1'b1, 6};
      vecs[5]  = '{32'hFFFE0010, 8'd1,  3'd1, 2'b01, 1'b0, 1'b1, 4};
      vecs[6]  = '{32'hFFFE0013, 8'd1,  3'd2, 2'b01, 1'b0, 1'b0, 4};
      vecs[7]  = '{32'hFFFE0020, 8'd3,  3'd2, 2'b00, 1'b1, 1'b0, 8};
      vecs[8]  = '{32'hFFFE0024, 8'd7,  3'd2, 2'b10, 1'b1, 1'b0, 9};
      vecs[9]  = '{32'hFFFE0014, 8'd15, 3'd2, 2'b10, 1'b0, 1'b0, 5};
      vecs[10] = '{32'hFFFE0000, 8'd0,  3'd2, 2'b11, 1'b0, 1'b1, 0};
      vecs[11] = '{32'hFFFE0028, 8'd3,  3'd3, 2'b01, 1'b1, 1'b1, 10};

      for (int i = 0; i < 64; i++) dut.mem[i] = word_val(i);
      for (int i = 16382; i < 16386; i++) dut.mem[i] = word_val(i);

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_rlast",   32'(rlast),   32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_rresp",   32'(rresp),   32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("arready_after_rst", 32'(arready), 32'd1);

      // Single beat: latency and arready return.
      do_read(32'hFFFE0000, 8'd0, 3'd2, 2'b01);
      push(32'hDEADBEEF, 2'b00, 1'b1);
      @(negedge clk);
      chk("lat_cycle0", 32'(rvalid), 32'd0);
      @(negedge clk);
      chk("lat_cycle1", 32'(rvalid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2", 32'(rvalid), 32'd1);
      @(negedge clk);
      chk("arready_after_last", 32'(arready), 32'd1);
      drain();

      // WRAP order written out by hand.
      do_read(32'hFFFE0018, 8'd3, 3'd2, 2'b10);
      push(32'd6, 2'b00, 1'b0);
      push(32'd7, 2'b00, 1'b0);
      push(32'd4, 2'b00, 1'b0);
      push(32'd5, 2'b00, 1'b1);
      drain();

      // Table of bursts.
      for (int v = 0; v < 12; v++) begin
         bp_mode = vecs[v].bp;
         bp_idx  = 0;
         do_read(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
         push_burst(vecs[v].exp_first, vecs[v].len, vecs[v].burst, vecs[v].exp_err);
         drain();
      end
      bp_mode = 1'b0;

      // INCR across DEPTH_WORDS.
      do_read(32'hFFFEFFF8, 8'd3, 3'd2, 2'b01);
      for (int b = 0; b < 4; b++) begin
         wi = 16382 + b;
`ifdef ROM_BOUNDS_CHECK_EN
         if (wi >= int'(Depth)) push(32'd0, 2'b10, b == 3);
         else push(word_val(wi), 2'b00, b == 3);
`else
         push(word_val(wi), 2'b00, b == 3);
`endif
      end
      drain();

      // Reset in the middle of a 16-beat burst.
      do_read(32'hFFFE0000, 8'd15, 3'd2, 2'b01);
      push_burst(0, 8'd15, 2'b01, 1'b0);
      p0 = n_pops;
      t  = 0;
      while (n_pops < p0 + 2 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("midburst_progress", 32'(n_pops - p0 >= 2), 32'd1);
      #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_rvalid",  32'(rvalid),  32'd0);
      chk("abort_rlast",   32'(rlast),   32'd0);
      chk("abort_rdata",   rdata,        32'd0);
      chk("abort_arready", 32'(arready), 32'd0);
      sb.delete();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_no_beats", 32'(rvalid), 32'd0);
      do_read(32'hFFFE0004, 8'd0, 3'd2, 2'b01);
      push(32'd1, 2'b00, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
